busca_instrucao: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC/next-address unit.

---
 rtl/pacote_busca.sv | 14 +
 rtl/fila_instrucao.sv | 67 ++++++
 rtl/busca_instrucao.sv | 95 +++++++++
 tb/tb_busca_instrucao.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_busca.sv
// Shared types and default widths for the instruction-fetch stage.
package pacote_busca;

  localparam int INSTR_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF  = 6;
  localparam int DEPTH_DEF       = 4;

  // One buffered fetch: the returned word and the address it came from.
  typedef struct packed {
    logic [INSTR_WIDTH_DEF-1:0] instr;
    logic [ADDR_WIDTH_DEF-1:0]  pc;
  } fifo_entry_t;

endpackage

// File: rtl/fila_instrucao.sv
// Synchronous FIFO of fetched instructions; clear has priority over push/pop.
module fila_instrucao
  import pacote_busca::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fifo_entry_t              din,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   ocupacao
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic          do_push, do_pop;
  fifo_entry_t   mem_q [DEPTH];

  // Self-protecting against underflow/overflow even though the top never asks.
  always_comb begin
    do_pop   = pop & (occ_q != '0);
    do_push  = push & ((occ_q != (PW+1)'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + (PW+1)'(1);
        2'b01:   occ_d = occ_q - (PW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: nothing is visible until occupancy says so.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign head     = mem_q[rd_ptr_q];
  assign ocupacao = occ_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: credit-gated memory issue, return buffering, decoder handshake.
// Optional same-cycle bypass of the returning word when BUSCA_BYPASS_EN is defined.
module busca_instrucao
  import pacote_busca::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,   // must equal the package widths
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_WIDTH-1:0]    cp,
  input  logic                     cp_valid,
  output logic                     cp_ready,
  input  logic                     flush,
  output logic                     mem_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0]   mem_rdata,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   ocupacao
);

  localparam int OW = $clog2(DEPTH) + 1;

  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] pc_pend_q, pc_pend_d;
  logic [OW:0]           credit_sum;
  logic                  credit_ok, issue;
  logic                  push, pop, fifo_vld;
  logic                  byp_vld, byp_take;
  fifo_entry_t           push_entry, head;

  // An in-flight read already owns a slot, so it counts against the credit.
  always_comb begin
    credit_sum = {1'b0, ocupacao} + (OW+1)'(inflight_q);
    credit_ok  = credit_sum < (OW+1)'(DEPTH);
    cp_ready   = reset_n & ~flush & credit_ok;
    issue      = cp_valid & cp_ready;
    mem_en     = issue;
    mem_addr   = cp;
    inflight_d = issue;
    pc_pend_d  = issue ? cp : pc_pend_q;
  end

`ifdef BUSCA_BYPASS_EN
  assign byp_vld  = (ocupacao == '0) & inflight_q & ~flush;
  assign byp_take = byp_vld & instr_ready;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  always_comb begin
    fifo_vld         = ocupacao != '0;
    pop              = fifo_vld & instr_ready;
    push             = inflight_q & ~flush & ~byp_take;
    push_entry.instr = mem_rdata;
    push_entry.pc    = pc_pend_q;
    instr_valid      = fifo_vld | byp_vld;
    instr            = '0;
    instr_pc         = '0;
    if (fifo_vld) begin
      instr    = head.instr;
      instr_pc = head.pc;
    end else if (byp_vld) begin
      instr    = mem_rdata;
      instr_pc = pc_pend_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      pc_pend_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      pc_pend_q  <= pc_pend_d;
    end
  end

  fila_instrucao #(.DEPTH(DEPTH)) u_fila (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .clear    (flush),
    .din      (push_entry),
    .head     (head),
    .ocupacao (ocupacao)
  );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed + random bench for busca_instrucao against a queue-based reference model.
module tb_busca_instrucao;

  localparam int AW    = 6;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
`ifdef BUSCA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cp = '0;
  logic          cp_valid = 1'b0;
  logic          cp_ready;
  logic          flush = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata = '0;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [OW-1:0] ocupacao;

  int checks = 0, passes = 0, fails = 0;

  logic [IW-1:0] tbl [64];
  // Model: every accepted fetch not yet consumed, oldest first; infl = issued last cycle.
  logic [IW-1:0] qi [$];
  logic [AW-1:0] qp [$];
  bit            infl = 1'b0;

  busca_instrucao #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .cp(cp), .cp_valid(cp_valid), .cp_ready(cp_ready),
    .flush(flush), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ocupacao(ocupacao)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int e_occ();
    return qi.size() - int'(infl);
  endfunction

  function automatic bit e_cpr();
    return reset_n && !flush && (qi.size() < DEPTH);
  endfunction

  function automatic bit e_vld();
    return reset_n && ((e_occ() > 0) || (BYP && infl && !flush));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    qi.delete();
    qp.delete();
    infl = 1'b0;
  endtask

  // One cycle: check outputs against the model, advance the model across the edge.
  task automatic step();
    bit            do_issue, do_pop, s_en;
    logic [AW-1:0] s_addr, s_cp;
    #1;
    chk("ocupacao", 64'(ocupacao), 64'(e_occ()));
    chk("cp_ready", 64'(cp_ready), 64'(e_cpr()));
    chk("instr_valid", 64'(instr_valid), 64'(e_vld()));
    chk("mem_en", 64'(mem_en), 64'(cp_valid && e_cpr()));
    if (cp_valid && e_cpr()) chk("mem_addr", 64'(mem_addr), 64'(cp));
    if (e_vld()) begin
      chk("instr", 64'(instr), 64'(qi[0]));
      chk("instr_pc", 64'(instr_pc), 64'(qp[0]));
    end
    do_issue = cp_valid && e_cpr();
    do_pop   = e_vld() && instr_ready;
    s_en     = mem_en;
    s_addr   = mem_addr;
    s_cp     = cp;
    @(posedge clock);
    if (do_pop) begin
      void'(qi.pop_front());
      void'(qp.pop_front());
    end
    if (flush) begin
      qi.delete();
      qp.delete();
    end
    if (do_issue) begin
      qi.push_back(tbl[s_cp]);
      qp.push_back(s_cp);
    end
    infl = do_issue;
    #1 mem_rdata = s_en ? tbl[s_addr] : IW'($urandom);
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    cp_valid = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < budget && qi.size() > 0; k++) step();
    chk("drain_empty", 64'(qi.size()), 64'(0));
  endtask

  initial begin
    int seen20;
    for (int a = 0; a < 64; a++) tbl[a] = 32'(a) + 32'd100;
    do_reset();
    @(negedge clock);
    #1;
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    chk("rst_cp_ready", 64'(cp_ready), 64'(0));
    step();
    reset_n = 1'b1;

    // Streaming 0..9 with the decoder always ready
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cp = AW'(i); cp_valid = 1'b1;
      #1;
      if (i == 1) chk("latency_c1", 64'(instr_valid), 64'(BYP));
      if (i == 2) chk("latency_c2", 64'(instr), 64'(BYP ? 101 : 100));
      step();
    end
    drain(8);

    // Backpressure until full, then pop from full, then push+pop together
    instr_ready = 1'b0; cp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin cp = AW'(20 + i); step(); end
    #1;
    chk("bp_full", 64'(ocupacao), 64'(DEPTH));
    chk("bp_cp_ready", 64'(cp_ready), 64'(0));
    cp_valid = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    chk("pop_full_occ", 64'(ocupacao), 64'(DEPTH - 1));
    chk("pop_full_credit", 64'(cp_ready), 64'(1));
    cp = AW'(40); cp_valid = 1'b1;
    step();
    cp_valid = 1'b0; instr_ready = 1'b1;
    step();
    #1;
    chk("pushpop_occ", 64'(ocupacao), 64'(DEPTH - 1));
    drain(10);

    // Reset mid-stream with three entries held
    instr_ready = 1'b0; cp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin cp = AW'(50 + i); step(); end
    cp_valid = 1'b0;
    step();
    chk("pre_rst_occ", 64'(ocupacao), 64'(3));
    cp_valid = 1'b1; cp = AW'(7);
    do_reset();
    #1;
    chk("mid_rst_valid", 64'(instr_valid), 64'(0));
    chk("mid_rst_occ", 64'(ocupacao), 64'(0));
    chk("mid_rst_cp_ready", 64'(cp_ready), 64'(0));
    chk("mid_rst_mem_en", 64'(mem_en), 64'(0));
    step();
    reset_n = 1'b1; cp = AW'(0);
    #1;
    chk("post_rst_fetch_addr", 64'(mem_addr), 64'(0));
    chk("post_rst_fetch_en", 64'(mem_en), 64'(1));
    step();
    drain(8);

    // Flush with two queued and one in flight, then redirect to 20
    instr_ready = 1'b0; cp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin cp = AW'(5 + i); step(); end
    cp_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_occ", 64'(ocupacao), 64'(0));
    chk("flush_valid", 64'(instr_valid), 64'(0));
    cp = AW'(20); cp_valid = 1'b1;
    step();
    cp_valid = 1'b0; instr_ready = 1'b1;
    seen20 = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (instr_valid) begin
        chk("post_flush_pc", 64'(instr_pc), 64'(20));
        seen20++;
      end
      step();
    end
    chk("post_flush_seen", 64'(seen20), 64'(1));

    // Random traffic: wrap the pointers many times with random readiness and rare flushes
    for (int a = 0; a < 64; a++) tbl[a] = $urandom;
    for (int i = 0; i < 120; i++) begin
      cp          = AW'($urandom);
      cp_valid    = ($urandom_range(0, 3) != 0);
      instr_ready = $urandom_range(0, 1) == 1;
      flush       = ($urandom_range(0, 24) == 0);
      step();
    end
    drain(12);
    #1;
    chk("final_occ", 64'(ocupacao), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
